// File: rtl/alu_arbiter.sv
// Two-requester arbiter that shares one combinational ALU and returns tagged results.
// Define ALU_ARB_FIXED_PRIO_EN to make requester 0 win every tie (no round-robin).
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_op,
    output logic [WIDTH-1:0] alu_R2,
    output logic [WIDTH-1:0] alu_R3,
    output logic [2:0]       alu_ALUOp,
    input  logic [WIDTH-1:0] alu_R0,
    input  logic             alu_overflow,
    input  logic             alu_zero,
    input  logic             alu_carry,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_R0,
    output logic             resp_overflow,
    output logic             resp_zero,
    output logic             resp_carry,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t state;
    logic   tie_id;
    logic   gnt0;
    logic   gnt1;
    logic   accept;

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign tie_id = 1'b0;
`else
    logic prio;
    assign tie_id = prio;
`endif

    // Grant depends only on the valid lines and the tie-break owner.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        unique case (1'b1)
            (req0_valid && req1_valid): begin
                gnt0 = ~tie_id;
                gnt1 = tie_id;
            end
            (req0_valid && !req1_valid): gnt0 = 1'b1;
            (!req0_valid && req1_valid): gnt1 = 1'b1;
            default: ;
        endcase
    end

    assign req0_ready = (state == IDLE) && gnt0;
    assign req1_ready = (state == IDLE) && gnt1;
    assign accept     = req0_ready || req1_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
`ifdef ALU_ARB_FIXED_PRIO_EN
`else
            prio          <= 1'b0;
`endif
            alu_R2        <= '0;
            alu_R3        <= '0;
            alu_ALUOp     <= '0;
            resp_R0       <= '0;
            resp_overflow <= 1'b0;
            resp_zero     <= 1'b0;
            resp_carry    <= 1'b0;
            resp_id       <= 1'b0;
            resp_valid    <= 1'b0;
            busy          <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        alu_R2    <= gnt1 ? req1_a : req0_a;
                        alu_R3    <= gnt1 ? req1_b : req0_b;
                        alu_ALUOp <= gnt1 ? req1_op : req0_op;
                        resp_id   <= gnt1;
`ifdef ALU_ARB_FIXED_PRIO_EN
`else
                        prio      <= ~gnt1;
`endif
                        busy      <= 1'b1;
                        state     <= EXEC;
                    end
                end
                EXEC: begin
                    resp_R0       <= alu_R0;
                    resp_overflow <= alu_overflow;
                    resp_zero     <= alu_zero;
                    resp_carry    <= alu_carry;
                    resp_valid    <= 1'b1;
                    state         <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed cases, then random traffic
// against a transaction-level model of arbitration and an ALU stand-in.
module tb_alu_arbiter;

    localparam int W = 32;
    localparam int P_IDLE = 0;
    localparam int P_EXEC = 1;
    localparam int P_RESP = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req0_valid, req1_valid;
    logic         req0_ready, req1_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]   req0_op, req1_op;
    logic [W-1:0] alu_R2, alu_R3, alu_R0;
    logic [2:0]   alu_ALUOp;
    logic         alu_overflow, alu_zero, alu_carry;
    logic         resp_valid, resp_ready, resp_id;
    logic [W-1:0] resp_R0;
    logic         resp_overflow, resp_zero, resp_carry, busy;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .alu_R2(alu_R2), .alu_R3(alu_R3), .alu_ALUOp(alu_ALUOp),
        .alu_R0(alu_R0), .alu_overflow(alu_overflow),
        .alu_zero(alu_zero), .alu_carry(alu_carry),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_R0(resp_R0),
        .resp_overflow(resp_overflow), .resp_zero(resp_zero),
        .resp_carry(resp_carry), .busy(busy)
    );

    // ALU stand-in; returns {overflow, zero, carry, result}.
    function automatic logic [35:0] alu_ref(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [2:0] op);
        logic [32:0] s;
        logic [31:0] r;
        logic c, o;
        c = 1'b0;
        o = 1'b0;
        case (op)
            3'd0: r = a & b;
            3'd1: r = a | b;
            3'd2: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[31:0];
                c = s[32];
                o = (a[31] == b[31]) && (r[31] != a[31]);
            end
            3'd3: begin
                s = {1'b0, a} - {1'b0, b};
                r = s[31:0];
                c = s[32];
                o = (a[31] != b[31]) && (r[31] != a[31]);
            end
            3'd4: r = a ^ b;
            default: begin
                r = a + {29'd0, op};
                c = op[0];
                o = op[1];
            end
        endcase
        return {o, (r == 32'd0), c, r};
    endfunction

    logic [35:0] alu_out;
    assign alu_out = alu_ref(alu_R2, alu_R3, alu_ALUOp);
    assign {alu_overflow, alu_zero, alu_carry, alu_R0} = alu_out;

    typedef struct {
        logic        id;
        logic [35:0] f;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   phase = P_IDLE;
    bit   mprio = 1'b0;
    int   last_acc = -1;
    int   cyc = 0;
    int   dut_acc_cyc[$];
    int   dut_acc_id[$];
    bit   pend[2];

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, got, exp, cyc);
        end
    endtask

    function automatic int model_grant();
        if (phase != P_IDLE) return -1;
        if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            return 0;
`else
            return int'(mprio);
`endif
        end
        if (req0_valid) return 0;
        if (req1_valid) return 1;
        return -1;
    endfunction

    // Checks one cycle against the model, then advances to the next negedge.
    task automatic tick();
        int   g;
        exp_t e;
        #1;
        g = model_grant();
        chk("req0_ready", req0_ready, g == 0);
        chk("req1_ready", req1_ready, g == 1);
        chk("resp_valid", resp_valid, phase == P_RESP);
        chk("busy", busy, phase != P_IDLE);
        if (req0_ready || req1_ready) begin
            dut_acc_cyc.push_back(cyc);
            dut_acc_id.push_back(int'(req1_ready));
        end
        last_acc = -1;
        case (phase)
            P_IDLE: begin
                if (g >= 0) begin
                    e.id = g[0];
                    e.f  = (g == 1) ? alu_ref(req1_a, req1_b, req1_op)
                                    : alu_ref(req0_a, req0_b, req0_op);
                    exp_q.push_back(e);
                    mprio    = (g == 0);
                    last_acc = g;
                    phase    = P_EXEC;
                end
            end
            P_EXEC: phase = P_RESP;
            default: if (resp_ready) phase = P_IDLE;
        endcase
        @(negedge clk);
        cyc++;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_alu_R2"}, alu_R2, 0);
        chk({tag, "_alu_R3"}, alu_R3, 0);
        chk({tag, "_alu_op"}, alu_ALUOp, 0);
        chk({tag, "_resp_R0"}, resp_R0, 0);
        chk({tag, "_flags"}, {resp_overflow, resp_zero, resp_carry}, 0);
        chk({tag, "_resp_id"}, resp_id, 0);
        chk({tag, "_resp_valid"}, resp_valid, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        exp_q.delete();
        phase = P_IDLE;
        mprio = 1'b0;
        #1;
        chk_zero(tag);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [31:0] a,
                           input logic [31:0] b, input logic [2:0] op);
        if (i == 0) begin
            req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
        end else begin
            req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
        end
    endtask

    task automatic new_op(input int i);
        logic [31:0] a, b;
        a = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom();
        b = ($urandom_range(0, 3) == 0) ? 32'd1 : $urandom();
        set_req(i, 1'b1, a, b, 3'($urandom_range(0, 7)));
        pend[i] = 1'b1;
    endtask

    // Monitor: pops and compares whenever a response handshake occurs.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && resp_valid && resp_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL resp_unexpected: id %0d R0 %0h",
                             resp_id, resp_R0);
                end else begin
                    e = exp_q.pop_front();
                    chk("resp_id", resp_id, e.id);
                    chk("resp_R0", resp_R0, e.f[31:0]);
                    chk("resp_flags",
                        {resp_overflow, resp_zero, resp_carry}, e.f[35:32]);
                end
            end
        end
    end

    initial begin
        int exp_ids[4];
        int hs;
        set_req(0, 1'b0, 0, 0, 0);
        set_req(1, 1'b0, 0, 0, 0);
        resp_ready = 1'b0;
        @(negedge clk);
        do_reset("reset");

        // Single add from requester 0
        set_req(0, 1'b1, 32'd5, 32'd7, 3'd2);
        resp_ready = 1'b1;
        tick();
        chk("t1_alu_R2", alu_R2, 5);
        chk("t1_alu_R3", alu_R3, 7);
        chk("t1_alu_op", alu_ALUOp, 2);
        req0_valid = 1'b0;
        tick();
        chk("t1_resp_valid", resp_valid, 1);
        chk("t1_resp_id", resp_id, 0);
        chk("t1_resp_R0", resp_R0, 12);
        tick();

        // Carry-out wrap to zero from requester 1
        set_req(1, 1'b1, 32'hFFFF_FFFF, 32'd1, 3'd2);
        tick();
        req1_valid = 1'b0;
        tick();
        chk("t3_resp_R0", resp_R0, 0);
        chk("t3_carry", resp_carry, 1);
        chk("t3_zero", resp_zero, 1);
        chk("t3_id", resp_id, 1);
        tick();

        // Both requesters saturating, response consumed immediately
        do_reset("reset2");
        dut_acc_cyc.delete();
        dut_acc_id.delete();
        new_op(0);
        new_op(1);
        resp_ready = 1'b1;
        repeat (12) begin
            tick();
            if (last_acc >= 0) new_op(last_acc);
        end
`ifdef ALU_ARB_FIXED_PRIO_EN
        exp_ids = '{0, 0, 0, 0};
`else
        exp_ids = '{0, 1, 0, 1};
`endif
        chk("t2_accept_count", dut_acc_id.size(), 4);
        for (int k = 0; k < 4 && k < dut_acc_id.size(); k++) begin
            chk($sformatf("t2_grant%0d", k), dut_acc_id[k], exp_ids[k]);
            if (k > 0)
                chk($sformatf("t2_spacing%0d", k),
                    dut_acc_cyc[k] - dut_acc_cyc[k-1], 3);
        end

        // Back-pressure: hold the response for 10 cycles
        resp_ready = 1'b0;
        for (int k = 0; k < 6 && phase != P_RESP; k++) tick();
        chk("t4_in_resp", resp_valid, 1);
        repeat (10) begin
            if (exp_q.size() > 0) begin
                chk("t4_hold_R0", resp_R0, exp_q[0].f[31:0]);
                chk("t4_hold_id", resp_id, exp_q[0].id);
            end
            tick();
        end
        resp_ready = 1'b1;
        hs = cyc;
        tick();
        tick();
        chk("t4_next_accept", dut_acc_cyc[$], hs + 1);

        // Operands frozen outside IDLE, then reset during EXEC
        set_req(0, 1'b0, 0, 0, 0);
        set_req(1, 1'b0, 0, 0, 0);
        repeat (4) tick();
        set_req(0, 1'b1, 32'd11, 32'd22, 3'd5);
        tick();
        req0_valid = 1'b0;
        set_req(1, 1'b1, 32'd99, 32'd98, 3'd1);
        resp_ready = 1'b0;
        chk("t5_exec_R2", alu_R2, 11);
        tick();
        chk("t5_resp_R2", alu_R2, 11);
        chk("t5_resp_R3", alu_R3, 22);
        chk("t5_resp_op", alu_ALUOp, 5);
        req1_valid = 1'b0;
        resp_ready = 1'b1;
        tick();
        set_req(0, 1'b1, 32'd33, 32'd44, 3'd3);
        tick();
        req0_valid = 1'b0;
        #1;
        do_reset("exec_reset");
        repeat (5) tick();

        // Random traffic
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        repeat (400) begin
            for (int i = 0; i < 2; i++)
                if (!pend[i] && $urandom_range(0, 2) == 0) new_op(i);
            req0_valid = pend[0];
            req1_valid = pend[1];
            resp_ready = ($urandom_range(0, 3) != 0);
            tick();
            if (last_acc >= 0) pend[last_acc] = 1'b0;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        resp_ready = 1'b1;
        repeat (6) tick();
        chk("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
